// File: rtl/circuit8_seq.sv
// circuit8_seq: multi-cycle CIRCUIT8 sequencer.
// z = ((a mod c) == 0) ? a - 1 : c + 1, with the MOD computed by one shared
// restoring-remainder stage that iterates once per bit of the dividend.
// Operands come in over a valid/ready handshake and the result goes out the same way.
module circuit8_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] c,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z,
  output logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             dbz_q, dbz_d;
  logic             ov_q, ov_d;

  // Remainder-stage scratch values.
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] g;

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      c_q     <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      c_q     <= c_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state and datapath sequencing: accept, iterate, finish, hand off.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    c_d     = c_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    dbz_d   = dbz_q;
    ov_d    = ov_q;

    // Shift in the next dividend bit; a borrow out of the MSB means t < c.
    t    = {rem_q, dvd_q[WIDTH-1]};
    diff = t - {1'b0, c_q};
    // Divide by zero leaves the remainder equal to the dividend.
    g    = (c_q == '0) ? a_q : rem_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          c_d     = c;
          dvd_d   = a;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (c == '0) ? S_FIN : S_DIV;
        end
      end
      S_DIV: begin
        rem_d = diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        z_d     = (g == '0) ? (a_q - WIDTH'(1)) : (c_q + WIDTH'(1));
        dbz_d   = (c_q == '0);
        ov_d    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake status decodes from the state register only.
  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign z           = z_q;
  assign div_by_zero = dbz_q;
  assign out_valid   = ov_q;

endmodule

// File: tb/tb_circuit8_seq.sv
// Bench for circuit8_seq: a transaction-level reference model checked every
// cycle, plus directed transactions with literal expected results and latencies.
module tb_circuit8_seq;

  localparam int unsigned W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         Clk;
  logic         Rst;
  logic [W-1:0] a;
  logic [W-1:0] c;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] z;
  logic         div_by_zero;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int total;
  int bad;

  circuit8_seq #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .a          (a),
    .c          (c),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z          (z),
    .div_by_zero(div_by_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result from the arithmetic definition, timing from the
  // latency rule (1 edge for c == 0, W+1 edges otherwise).
  logic         m_busy, m_valid, m_dbz, p_dbz;
  logic [W-1:0] m_z, p_z, g;
  int           m_cnt;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
      m_z = '0; m_dbz = 1'b0; p_z = '0; p_dbz = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        g      = (c == '0) ? a : (a % c);
        p_z    = (g == '0) ? a - 64'd1 : c + 64'd1;
        p_dbz  = (c == '0);
        m_cnt  = (c == '0) ? 1 : W + 1;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_z     = p_z;
        m_dbz   = p_dbz;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge Clk) begin
    chk("mdl_out_valid", 64'(out_valid), 64'(m_valid));
    chk("mdl_z", z, m_z);
    chk("mdl_dbz", 64'(div_by_zero), 64'(m_dbz));
    chk("mdl_busy", 64'(busy), 64'(m_busy));
    chk("mdl_in_ready", 64'(in_ready), 64'(!m_busy));
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge Clk); #1; n++;
    end
    chk("wait_in_ready", 64'(in_ready), 64'd1);
  endtask

  // One transaction with literal expectations; optional backpressure and
  // operand changes while the division is running.
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tc,
                     input logic [W-1:0] ez, input logic edbz, input int elat,
                     input int hold, input bit mutate);
    int n;
    wait_ready();
    a = ta; c = tc; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge Clk); n++; #1;
      if (mutate && n == 5) begin
        a = ~ta; c = 64'd3;
      end
      if (out_valid) break;
    end
    chk("latency", 64'(n), 64'(elat));
    chk("z_lit", z, ez);
    chk("dbz_lit", 64'(div_by_zero), 64'(edbz));
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_z", z, ez);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    Rst = 1'b0; in_valid = 1'b1; a = 64'd20; c = 64'd5; out_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_z", z, 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; Rst = 1'b1;
    @(posedge Clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);

    run(64'd20, 64'd5, 64'd19, 1'b0, 65, 0, 1'b0);
    run(64'd21, 64'd5, 64'd6, 1'b0, 65, 0, 1'b0);
    run(64'd0, 64'd3, ONES, 1'b0, 65, 0, 1'b0);
    run(64'd7, 64'd0, 64'd1, 1'b1, 1, 0, 1'b0);
    run(64'd0, 64'd0, ONES, 1'b1, 1, 0, 1'b0);
    run(64'd5, ONES, 64'd0, 1'b0, 65, 10, 1'b1);
    run(64'd1000, 64'd7, 64'd8, 1'b0, 65, 2, 1'b1);

    // Reset in the middle of a division.
    wait_ready();
    a = 64'd100; c = 64'd7; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge Clk);
    #1;
    chk("mid_busy_pre", 64'(busy), 64'd1);
    Rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    run(64'd100, 64'd7, 64'd8, 1'b0, 65, 0, 1'b0);

    repeat (3) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
